rs_syndrome_calc: RTL and testbench

RS_SYNDROME_CALC -- requirements
Module: rs_syndrome_calc

---
 rtl/rs_syndrome_calc_pkg.sv | 44 ++++
 rtl/rs_syndrome_calc_if.sv | 32 +++
 rtl/rs_syndrome_cell.sv | 43 ++++
 rtl/rs_syndrome_calc.sv | 123 ++++++++++++
 tb/tb_rs_syndrome_calc.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rs_syndrome_calc_pkg.sv
// Shared definitions for the RS(N) syndrome calculator over GF(2^8).
//   SYM_W/CNT_W  : symbol and codeword-counter widths
//   NSYM         : number of syndromes (S1..S6)
//   GF_POLY      : primitive polynomial x^8+x^4+x^3+x^2+1
//   ALPHA_POWS   : alpha^1..alpha^6, packed lowest power in the low byte
//   state_e      : FSM encoding
package rs_syndrome_calc_pkg;

    localparam int unsigned SYM_W     = 8;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned NSYM      = 6;
    localparam int unsigned DEFAULT_N = 255;

    localparam logic [SYM_W:0] GF_POLY = 9'h11D;

    localparam logic [NSYM*SYM_W-1:0] ALPHA_POWS =
        {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Multiply by alpha (x): shift and fold the overflow bit back in.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] x);
        return {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? GF_POLY[SYM_W-1:0] : SYM_W'(0));
    endfunction

    // Multiply by a constant; with c fixed this reduces to a pure XOR network.
    function automatic logic [SYM_W-1:0] gf_mul_const(input logic [SYM_W-1:0] x,
                                                      input logic [SYM_W-1:0] c);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] t;
        p = '0;
        t = x;
        for (int k = 0; k < int'(SYM_W); k++) begin
            if (c[k]) p = p ^ t;
            t = gf_xtime(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Symbol stream in / syndrome set out.
//   sym_in, sym_valid, sym_first : symbol stream from the receiver
//   sym_ready                    : calculator accepts a symbol this cycle
//   w1..w6, signal, err_det      : syndrome set, its strobe and non-zero flag
interface rs_syndrome_calc_if
    import rs_syndrome_calc_pkg::*;
();

    logic [SYM_W-1:0] sym_in;
    logic             sym_valid;
    logic             sym_first;
    logic             sym_ready;
    logic [SYM_W-1:0] w1;
    logic [SYM_W-1:0] w2;
    logic [SYM_W-1:0] w3;
    logic [SYM_W-1:0] w4;
    logic [SYM_W-1:0] w5;
    logic [SYM_W-1:0] w6;
    logic             signal;
    logic             err_det;

    modport master (
        output sym_in, sym_valid, sym_first,
        input  sym_ready, w1, w2, w3, w4, w5, w6, signal, err_det
    );

    modport slave (
        input  sym_in, sym_valid, sym_first,
        output sym_ready, w1, w2, w3, w4, w5, w6, signal, err_det
    );

endinterface

// File: rtl/rs_syndrome_cell.sv
// One Horner accumulator: acc <= load ? sym : acc*ALPHA ^ sym.
//   clk, rst_n : clock, async active-low reset
//   load_i     : start of codeword, load sym_i directly
//   upd_i      : continuation symbol, multiply-accumulate
//   sym_i      : incoming symbol
//   acc_o      : current accumulator value
module rs_syndrome_cell
    import rs_syndrome_calc_pkg::*;
#(
    parameter logic [SYM_W-1:0] ALPHA = 8'h02
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             upd_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic [SYM_W-1:0] acc_o
);

    logic [SYM_W-1:0] acc_q;
    logic [SYM_W-1:0] acc_d;

    // Load wins over update; both are exclusive in practice.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = sym_i;
        end else if (upd_i) begin
            acc_d = gf_mul_const(acc_q, ALPHA) ^ sym_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(N) syndrome calculator: evaluates S1..S6 of a received codeword by Horner's
// rule and presents them, registered, for one strobe cycle after the codeword.
//   clk, rst_n : clock, async active-low reset
//   bus        : symbol stream in, syndrome set / signal / err_det out
module rs_syndrome_calc
    import rs_syndrome_calc_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rs_syndrome_calc_if.slave    bus
);

    localparam int unsigned CMP_W = CNT_W + 1;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         ready_q, ready_d;
    logic                         signal_q, signal_d;
    logic                         err_det_q, err_det_d;
    logic [NSYM-1:0][SYM_W-1:0]   w_q, w_d;
    logic [NSYM-1:0][SYM_W-1:0]   acc_c;

    logic accept_c;
    logic last_c;
    logic load_c;
    logic upd_c;

    assign accept_c = bus.sym_valid & ready_q;
    // Symbol being accepted now is the N-th of the codeword.
    assign last_c   = (CMP_W'(cnt_q) + CMP_W'(1)) == CMP_W'(N);

    // Next-state, accumulator control and output-register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        err_det_d = err_det_q;
        signal_d  = 1'b0;
        load_c    = 1'b0;
        upd_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c && bus.sym_first) begin
                    load_c  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept_c) begin
                    if (bus.sym_first) begin
                        load_c = 1'b1;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        upd_c = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_c) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_d       = acc_c;
                err_det_d = |acc_c;
                signal_d  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stall the stream only for the single cycle spent in DONE.
        ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            signal_q  <= 1'b0;
            err_det_q <= 1'b0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            signal_q  <= signal_d;
            err_det_q <= err_det_d;
            w_q       <= w_d;
        end
    end

    // One accumulator per syndrome, each with its own constant alpha^j.
    for (genvar g = 0; g < int'(NSYM); g++) begin : g_cell
        rs_syndrome_cell #(
            .ALPHA (ALPHA_POWS[g*SYM_W +: SYM_W])
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load_c),
            .upd_i  (upd_c),
            .sym_i  (bus.sym_in),
            .acc_o  (acc_c[g])
        );
    end

    assign bus.sym_ready = ready_q;
    assign bus.w1        = w_q[0];
    assign bus.w2        = w_q[1];
    assign bus.w3        = w_q[2];
    assign bus.w4        = w_q[3];
    assign bus.w5        = w_q[4];
    assign bus.w6        = w_q[5];
    assign bus.signal    = signal_q;
    assign bus.err_det   = err_det_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Scoreboard bench for rs_syndrome_calc: the driver pushes the syndromes of each
// complete codeword (direct polynomial evaluation) and the monitor compares them
// whenever signal is high.
module tb_rs_syndrome_calc;
    import rs_syndrome_calc_pkg::*;

    localparam int N = 255;

    typedef struct packed {
        logic [5:0][7:0] s;
        logic            err;
        int              cyc;
    } exp_s;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_syndrome_calc_if bus();

    rs_syndrome_calc #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_s       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] alog [255];
    logic [7:0] cw   [N];

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // S_j = sum r_i * alpha^(j*deg_i), evaluated term by term.
    function automatic exp_s model(int cyc_exp);
        exp_s e;
        e.s = '0;
        for (int j = 1; j <= 6; j++) begin
            for (int i = 0; i < N; i++) begin
                e.s[j-1] = e.s[j-1] ^ gf_mul(cw[i], alog[(j * (N - 1 - i)) % 255]);
            end
        end
        e.err = |e.s;
        e.cyc = cyc_exp;
        return e;
    endfunction

    task automatic chk(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pop and compare on every signal pulse.
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        exp_s e;
        if (bus.signal === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_signal: got pulse want none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("w1", 32'(bus.w1), 32'(e.s[0]));
                chk("w2", 32'(bus.w2), 32'(e.s[1]));
                chk("w3", 32'(bus.w3), 32'(e.s[2]));
                chk("w4", 32'(bus.w4), 32'(e.s[3]));
                chk("w5", 32'(bus.w5), 32'(e.s[4]));
                chk("w6", 32'(bus.w6), 32'(e.s[5]));
                chk("err_det", 32'(bus.err_det), 32'(e.err));
                chk("signal_cycle", cyc, e.cyc);
                chk("ready_in_done", 32'(ready_prev), 0);
                chk("ready_after_done", 32'(bus.sym_ready), 1);
            end
        end
        ready_prev = bus.sym_ready;
    end

    task automatic idle_cycle();
        bus.sym_valid = 1'b0;
        bus.sym_in    = 8'($urandom);
        bus.sym_first = 1'($urandom);
        @(negedge clk);
    endtask

    // Present one symbol from a negedge and hold it until it is accepted.
    task automatic send(logic [7:0] s, logic f);
        int waits = 0;
        bus.sym_valid = 1'b1;
        bus.sym_in    = s;
        bus.sym_first = f;
        while (bus.sym_ready !== 1'b1) begin
            if (waits == 8) begin
                n_vec++;
                n_err++;
                $display("FAIL ready_timeout: got sym_ready=0 for %0d cycles want 1", waits);
                bus.sym_valid = 1'b0;
                return;
            end
            waits++;
            @(negedge clk);
        end
        @(negedge clk);
        bus.sym_valid = 1'b0;
    endtask

    task automatic send_cw(int n, int gap_pct, bit complete);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            while (g < 3 && $urandom_range(99) < gap_pct) begin
                idle_cycle();
                g++;
            end
            send(cw[i], i == 0);
        end
        // Last symbol accepted on edge 'cyc'; strobe visible one edge later.
        if (complete) exp_q.push_back(model(cyc + 1));
    endtask

    task automatic fill(int mode);
        for (int i = 0; i < N; i++) cw[i] = (mode == 0) ? 8'h00 : 8'($urandom);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_w1"}, 32'(bus.w1), 0);
        chk({tag, "_w2"}, 32'(bus.w2), 0);
        chk({tag, "_w3"}, 32'(bus.w3), 0);
        chk({tag, "_w4"}, 32'(bus.w4), 0);
        chk({tag, "_w5"}, 32'(bus.w5), 0);
        chk({tag, "_w6"}, 32'(bus.w6), 0);
        chk({tag, "_signal"}, 32'(bus.signal), 0);
        chk({tag, "_err_det"}, 32'(bus.err_det), 0);
        chk({tag, "_ready"}, 32'(bus.sym_ready), 0);
    endtask

    initial begin
        bus.sym_valid = 1'b0;
        bus.sym_in    = 8'h00;
        bus.sym_first = 1'b0;
        alog[0] = 8'h01;
        for (int i = 1; i < 255; i++) alog[i] = gf_mul(alog[i-1], 8'h02);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(bus.sym_ready), 1);

        // Stray non-first symbols in IDLE are discarded; then all-zero codeword.
        send(8'hAA, 1'b0);
        send(8'h5C, 1'b0);
        fill(0);
        send_cw(N, 0, 1);

        // Only the degree-0 symbol non-zero: every syndrome equals it.
        fill(0);
        cw[N-1] = 8'h05;
        send_cw(N, 0, 1);

        // Only the degree-1 symbol set: syndromes are alpha^1..alpha^6.
        fill(0);
        cw[253] = 8'h01;
        send_cw(N, 0, 1);

        // Same codeword with random valid gaps.
        send_cw(N, 30, 1);

        // Restart after 100 symbols; only the second codeword counts.
        fill(1);
        send_cw(100, 0, 0);
        fill(1);
        send_cw(N, 0, 1);
        repeat (4) idle_cycle();

        // Reset mid-codeword discards it; the next codeword decodes normally.
        fill(1);
        send_cw(150, 10, 0);
        rst_n = 1'b0;
        idle_cycle();
        idle_cycle();
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        idle_cycle();
        fill(1);
        send_cw(N, 10, 1);

        // Random codewords, back to back, with gaps and strays in between.
        for (int k = 0; k < 3; k++) begin
            if ($urandom_range(1) == 1) send(8'($urandom), 1'b0);
            fill(1);
            send_cw(N, 20, 1);
        end

        repeat (6) idle_cycle();
        chk("pending_expected", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
